bcd_converter: RTL
==================

# bcd_converter

Sequential binary-to-BCD converter for the eight-digit seven-segment display path. It takes the binary generation count from the Game of Life core and converts it into eight BCD digits with an iterative shift-add-3 (double-dabble) algorithm. The digits are registered and held stable between conversions. They feed the digit-select multiplexer, which scans them onto the display.

## Interface
- `BIN_W`, default 27; width of the binary input. 27 bits covers 99,999,999; legal range is 4..32.
- `clk` input, 1 bit; system clock. All state changes on its rising edge.
- `reset` input, 1 bit; synchronous, active-high reset.
- `start` input, 1 bit; request a conversion of `bin_in`. Sampled only in IDLE.
- `bin_in` input, `BIN_W` bits; unsigned binary value. Captured on the edge that accepts `start`.
- `busy` output, 1 bit; high whenever the state is not IDLE.
- `done` output, 1 bit; single-cycle pulse when new digits are valid.
- `overflow` output, 1 bit; the last accepted value exceeded 99,999,999. Updated together with the digits.
- `digit1`..`digit8` outputs, 4 bits each; BCD result. `digit1` is the least significant (rightmost) digit and `digit8` the most significant.

## Operation
- The state machine has three states: IDLE, SHIFT and LOAD.
- **IDLE, with `start`=1:**
  - Capture `bin_in` into the shift register.
  - Clear the 32-bit BCD scratch register and the iteration counter.
  - Set the internal overflow flag if `bin_in` > 99,999,999.
  - Go to SHIFT.
- **IDLE, with `start`=0:** stay in IDLE. Outputs hold their values.
- **SHIFT:** each cycle performs one iteration:
  - In every scratch nibble with a value of 5 or more, add 3.
  - Then shift {scratch, binary} left by one bit, so the binary MSB enters scratch bit 0.
  - Increment the counter.
  - After exactly `BIN_W` iterations, go to LOAD.
- **LOAD:**
  - Copy the scratch nibbles to `digit1`..`digit8`. If the overflow flag is set, load 9 into all eight digits instead.
  - Copy the flag to `overflow`.
  - Assert `done`, then return to IDLE.
- **`start` while busy:** `start` asserted in SHIFT or LOAD is ignored. It is not queued.
- **Scratch arithmetic:** the adjust-and-shift is done in 4-bit lanes. With the range check in place, no lane carries beyond 4 bits. Scratch bits above digit 8 are not kept.
- **Digit outputs between conversions:** the digit outputs and `overflow` change only in LOAD and on reset. The display never shows a partially converted value.
- **Reset:** takes effect in any state, including mid-SHIFT.
  - State returns to IDLE.
  - `busy`, `done` and `overflow` go to 0.
  - Scratch, counter and all digits go to 0, except where blanking changes the digit reset values (see Configuration).
  - No `done` is produced for an interrupted conversion.

## Timing
- Start is accepted at rising edge k. SHIFT iterations occur on edges k+1 through k+`BIN_W`.
- At edge k+`BIN_W`+1, the digits and `overflow` update and `done` rises. `done` is high for that one cycle only.
- `busy` is high from edge k until edge k+`BIN_W`+2, when the block is back in IDLE.
- The earliest next start is accepted at edge k+`BIN_W`+2. Throughput is one conversion per `BIN_W`+2 cycles.
- With the default `BIN_W`=27, `done` follows the accepting edge by 28 cycles.

## Configuration
- The macro `BCD_LEADING_BLANK_EN` controls leading-zero blanking.
- **With the macro defined:**
  - In LOAD, every digit above the most significant nonzero digit is loaded as 4'hF, the blank code. The downstream segment decoder drives all segments off for 4'hF.
  - `digit1` is never blanked, so a value of 0 displays as a single "0".
  - In the overflow case, no digits are blanked.
  - Reset values are `digit1`=0 and `digit2`..`digit8`=4'hF.
- **Without the macro:** all eight digits are always loaded as BCD, leading zeros included, and all digits reset to 0.

## Test plan
- **Reset:** hold reset for 2 cycles. Then `busy`=0, `done`=0, `overflow`=0, and the digits equal the reset values for the build.
- **Typical value:** `bin_in`=12,345,678 with a one-cycle `start`. `done` pulses exactly 28 cycles later, with `digit8`..`digit1`=1,2,3,4,5,6,7,8 and `overflow`=0.
- **Zero and blanking:** `bin_in`=0 gives all digits 0. With `BCD_LEADING_BLANK_EN`, `digit1`=0 and `digit2`..`digit8`=4'hF. Also, `bin_in`=305 with the macro gives `digit3`..`digit1`=3,0,5 and `digit4`..`digit8`=4'hF.
- **Boundaries:** `bin_in`=99,999,999 gives all 9s with `overflow`=0. `bin_in`=100,000,000 gives all 9s with `overflow`=1.
- **Start while busy:** convert 42, then pulse `start` with `bin_in`=7 during SHIFT. Only one `done` occurs, the result is 42, and the digits stay unchanged afterwards until a new start in IDLE.
- **Reset mid-conversion:** assert reset 10 cycles into a conversion of 5,555. No `done` pulse occurs, the outputs show reset values, and a new conversion of 9 then completes correctly 28 cycles after its start.

Source files
------------

// File: rtl/bcd_converter.sv
// Iterative binary-to-BCD (double-dabble) converter for the eight-digit display path.
// Optional leading-zero blanking is enabled by defining BCD_LEADING_BLANK_EN.
module bcd_converter #(
  parameter int unsigned BIN_W = 27
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [3:0]       digit1,
  output logic [3:0]       digit2,
  output logic [3:0]       digit3,
  output logic [3:0]       digit4,
  output logic [3:0]       digit5,
  output logic [3:0]       digit6,
  output logic [3:0]       digit7,
  output logic [3:0]       digit8
);

  localparam int unsigned CNT_W   = $clog2(BIN_W + 1);
  localparam logic [32:0] MAX_DEC = 33'd99_999_999;

`ifdef BCD_LEADING_BLANK_EN
  localparam logic [31:0] DIG_RST = 32'hFFFF_FFF0;
`else
  localparam logic [31:0] DIG_RST = 32'h0000_0000;
`endif

  typedef enum logic [1:0] {StIdle, StShift, StLoad} state_e;

  state_e           state_q;
  logic [BIN_W-1:0] bin_q;
  logic [31:0]      scratch_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic [31:0]      dig_q;

  logic [32:0]      bin_ext;
  logic [31:0]      scratch_adj;
  logic [31:0]      scratch_nxt;
  logic [31:0]      load_dig;

  assign bin_ext = 33'(bin_in);

  // Add-3 in each 4-bit lane, then shift the binary MSB into the scratch LSB.
  always_comb begin
    scratch_adj = scratch_q;
    for (int i = 0; i < 8; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
    scratch_nxt = {scratch_adj[30:0], bin_q[BIN_W-1]};
  end

`ifdef BCD_LEADING_BLANK_EN
  logic lead;

  always_comb begin
    load_dig = scratch_q;
    lead     = 1'b1;
    if (ovf_q) begin
      load_dig = 32'h9999_9999;
    end else begin
      // digit1 is never blanked so zero still shows as a single "0".
      for (int i = 7; i >= 1; i--) begin
        if (lead && (scratch_q[4*i +: 4] == 4'd0)) begin
          load_dig[4*i +: 4] = 4'hF;
        end else begin
          lead = 1'b0;
        end
      end
    end
  end
`else
  always_comb begin
    load_dig = scratch_q;
    if (ovf_q) begin
      load_dig = 32'h9999_9999;
    end
  end
`endif

  // The digits are registered on entry to LOAD so that done and the new
  // digits appear in the same cycle while busy is still high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      bin_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      dig_q     <= DIG_RST;
      overflow  <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            bin_q     <= bin_in;
            scratch_q <= '0;
            cnt_q     <= '0;
            ovf_q     <= (bin_ext > MAX_DEC);
            state_q   <= StShift;
          end
        end
        StShift: begin
          if (cnt_q == CNT_W'(BIN_W)) begin
            dig_q    <= load_dig;
            overflow <= ovf_q;
            done     <= 1'b1;
            state_q  <= StLoad;
          end else begin
            scratch_q <= scratch_nxt;
            bin_q     <= bin_q << 1;
            cnt_q     <= cnt_q + 1'b1;
            // A carry out of the top lane can only come from an out-of-range value.
            ovf_q     <= ovf_q | scratch_adj[31];
          end
        end
        StLoad: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy   = (state_q != StIdle);
  assign digit1 = dig_q[3:0];
  assign digit2 = dig_q[7:4];
  assign digit3 = dig_q[11:8];
  assign digit4 = dig_q[15:12];
  assign digit5 = dig_q[19:16];
  assign digit6 = dig_q[23:20];
  assign digit7 = dig_q[27:24];
  assign digit8 = dig_q[31:28];

endmodule
